// File: rtl/vga_timing_pkg.sv
// Shared VGA raster defaults (640x480@60) for the sync generator and the sync decoder.
package vga_timing_pkg;

  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned H_START   = 144;
  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned V_START   = 34;
  localparam int unsigned V_DISPLAY = 480;
  localparam logic        SYNC_POL  = 1'b0;

  function automatic logic in_window(input logic [31:0] cnt, input int unsigned start,
                                     input int unsigned len);
    return (cnt >= start) && (cnt < start + len);
  endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Pixel-rate sync stream: the generator drives it, the decoder consumes it.
interface vga_sync_decoder_if;

  logic pixel_tick;
  logic hsync;
  logic vsync;

  modport master (output pixel_tick, hsync, vsync);
  modport slave  (input  pixel_tick, hsync, vsync);

endinterface

// File: rtl/vga_sync_decoder_sync_edge_detect.sv
// Normalises a sync line to active-high, samples it on pixel ticks and flags its start edge.
module sync_edge_detect #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sync_in,
  output logic start
);

  logic active;
  logic q;

  assign active = ~(sync_in ^ POL);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (tick) begin
      q <= active;
    end
  end

  assign start = tick & active & ~q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from an hsync/vsync stream, measures raster size and tracks lock.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int unsigned H_START     = vga_timing_pkg::H_START,
  parameter int unsigned H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int unsigned V_START     = vga_timing_pkg::V_START,
  parameter int unsigned V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter logic        SYNC_POL    = vga_timing_pkg::SYNC_POL,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned CW          = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_sync_decoder_if.slave    sync_in,
  output logic [CW-1:0]        pixel_x,
  output logic [CW-1:0]        pixel_y,
  output logic                 video_on,
  output logic                 frame_start,
  output logic                 locked,
  output logic [CW-1:0]        h_total,
  output logic [CW-1:0]        v_total
);

  localparam int unsigned   GW         = $clog2(LOCK_FRAMES + 2);
  localparam logic [CW-1:0] CNT_MAX    = '1;
  localparam logic [CW-1:0] H_TOTAL_C  = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_TOTAL_C  = CW'(V_TOTAL);
  localparam logic [CW-1:0] H_START_C  = CW'(H_START);
  localparam logic [CW-1:0] V_START_C  = CW'(V_START);
  localparam logic [GW-1:0] LOCK_C     = GW'(LOCK_FRAMES);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic          hs_start, vs_start;
  logic [CW-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic [CW-1:0] h_total_nxt, v_total_nxt, px_nxt, py_nxt;
  logic [GW-1:0] good, good_nxt;
  logic          v_pend, v_pend_nxt, have_h, have_h_nxt, have_v, have_v_nxt;
  logic          frame_ok, frame_ok_nxt, locked_nxt, vo_nxt, fs_nxt;
  logic          line_err, reload, win;

  sync_edge_detect #(.POL(SYNC_POL)) u_hs_edge (
    .clk     (clk),
    .reset   (reset),
    .tick    (sync_in.pixel_tick),
    .sync_in (sync_in.hsync),
    .start   (hs_start)
  );

  sync_edge_detect #(.POL(SYNC_POL)) u_vs_edge (
    .clk     (clk),
    .reset   (reset),
    .tick    (sync_in.pixel_tick),
    .sync_in (sync_in.vsync),
    .start   (vs_start)
  );

  always_comb begin
    h_nxt        = h_cnt;
    v_nxt        = v_cnt;
    v_pend_nxt   = v_pend;
    have_h_nxt   = have_h;
    have_v_nxt   = have_v;
    h_total_nxt  = h_total;
    v_total_nxt  = v_total;
    frame_ok_nxt = frame_ok;
    good_nxt     = good;
    locked_nxt   = locked;
    px_nxt       = pixel_x;
    py_nxt       = pixel_y;
    vo_nxt       = video_on;
    fs_nxt       = 1'b0;
    line_err     = 1'b0;
    reload       = 1'b0;
    win          = 1'b0;

    if (sync_in.pixel_tick) begin
      if (hs_start) begin
        h_nxt      = '0;
        have_h_nxt = 1'b1;
        if (have_h) begin
          h_total_nxt = sat_inc(h_cnt);
          line_err    = (h_total_nxt != H_TOTAL_C);
        end
      end else if (h_cnt == CNT_MAX) begin
        line_err = 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end

      // A vsync start on the same tick as hsync reloads v_cnt right away.
      if (vs_start) v_pend_nxt = 1'b1;
      if (hs_start) begin
        if (v_pend || vs_start) begin
          reload     = 1'b1;
          v_nxt      = '0;
          v_pend_nxt = 1'b0;
          fs_nxt     = 1'b1;
          have_v_nxt = 1'b1;
          if (have_v) v_total_nxt = sat_inc(v_cnt);
        end else begin
          v_nxt = sat_inc(v_cnt);
        end
      end

      if (line_err) begin
        good_nxt     = '0;
        locked_nxt   = 1'b0;
        frame_ok_nxt = 1'b0;
      end

      // The line closed by this hsync still belongs to the frame being judged.
      if (reload) begin
        if (have_v) begin
          if (frame_ok && !line_err && v_total_nxt == V_TOTAL_C) begin
            if (good != LOCK_C) good_nxt = good + 1'b1;
          end else begin
            good_nxt = '0;
          end
          locked_nxt = (good_nxt == LOCK_C);
        end
        frame_ok_nxt = 1'b1;
      end

      win    = in_window(32'(h_nxt), H_START, H_DISPLAY) &
               in_window(32'(v_nxt), V_START, V_DISPLAY);
      vo_nxt = locked_nxt & win;
      px_nxt = vo_nxt ? h_nxt - H_START_C : '0;
      py_nxt = vo_nxt ? v_nxt - V_START_C : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      v_pend      <= 1'b0;
      have_h      <= 1'b0;
      have_v      <= 1'b0;
      frame_ok    <= 1'b0;
      good        <= '0;
      locked      <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      v_pend      <= v_pend_nxt;
      have_h      <= have_h_nxt;
      have_v      <= have_v_nxt;
      frame_ok    <= frame_ok_nxt;
      good        <= good_nxt;
      locked      <= locked_nxt;
      h_total     <= h_total_nxt;
      v_total     <= v_total_nxt;
      pixel_x     <= px_nxt;
      pixel_y     <= py_nxt;
      video_on    <= vo_nxt;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA sync signals generator.
- Consumes pixel_tick, hsync and vsync, and recovers pixel_x, pixel_y and video_on.
- Measures line length and frame height, and asserts locked once timing matches the expected 640x480 raster.
- Used as the monitor/loopback checker for the generator, and as the front end of any block that ingests a VGA-timed stream.

Parameters:
- H_TOTAL, 800: expected pixel ticks per line.
- V_TOTAL, 525: expected lines per frame.
- H_START, 144: h_cnt value of the first active pixel (sync 96 + back porch 48).
- H_DISPLAY, 640: active pixels per line.
- V_START, 34: v_cnt value of the first active row (vsync 2 + back porch 33 - 1; the generator's hsync precedes the active region of the next line).
- V_DISPLAY, 480: active rows.
- SYNC_POL, 0: asserted level of hsync/vsync (0 = active low).
- LOCK_FRAMES, 2: consecutive clean frames required before locked rises.
- CW, 11: counter/coordinate width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_tick  in  1  pixel-rate enable; all sampling and counting happens only on clk edges with pixel_tick=1
- hsync  in  1  horizontal sync, polarity per SYNC_POL
- vsync  in  1  vertical sync, polarity per SYNC_POL
- pixel_x  out  CW  h_cnt - H_START while active, else 0
- pixel_y  out  CW  v_cnt - V_START while active, else 0
- video_on  out  1  locked AND h/v counters inside the active window
- frame_start  out  1  one-clk pulse when v_cnt reloads to 0
- locked  out  1  raster timing matches H_TOTAL/V_TOTAL
- h_total  out  CW  last measured line length, in ticks
- v_total  out  CW  last measured frame height, in lines

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-high, and takes priority over pixel_tick. All outputs, counters, sampled syncs, have_h/have_v flags and good-frame count go to 0.
- Sync normalisation: hs_a = hsync XNOR SYNC_POL, vs_a likewise.
- Sampling: on each tick, hs_q <= hs_a and vs_q <= vs_a.
- Edge detection (combinational, qualified by tick):
  - hs_start = hs_a & ~hs_q
  - vs_start = vs_a & ~vs_q
- Horizontal counting, on tick:
  - If hs_start: h_cnt <= 0; if have_h, h_total <= h_cnt+1; have_h <= 1.
  - Else h_cnt <= h_cnt+1, saturating at 2^CW-1. Saturation counts as a line error.
- Vertical counting:
  - vs_start sets v_pend.
  - On hs_start: if v_pend, then v_cnt <= 0, v_pend <= 0, frame_start pulses, and if have_v, v_total <= v_cnt+1 and the frame is evaluated; have_v <= 1.
  - Otherwise on hs_start, v_cnt <= v_cnt+1, saturating.
  - vs_start and hs_start on the same tick: v_pend is consumed immediately, so v_cnt <= 0 on that tick.
- Frame check:
  - A frame is clean if v_total == V_TOTAL and every line in it measured h_total == H_TOTAL, with no saturation.
  - The good count increments on each clean frame and stops incrementing at LOCK_FRAMES.
  - locked <= 1 when the count reaches LOCK_FRAMES.
- Loss of lock: any line error, or a frame with the wrong v_total, clears locked and the good count on that same tick. The next frame restarts evaluation.
- Output window: video_on = locked & (H_START ≤ h_cnt < H_START+H_DISPLAY) & (V_START ≤ v_cnt < V_START+V_DISPLAY).
- Registering and latency:
  - pixel_x, pixel_y, video_on and frame_start are registered from the counters.
  - Latency is one tick from the pixel's sync sample to the outputs.
  - Outputs hold their values between ticks.
- Stall: with pixel_tick low, no state changes; frame_start is 0.
- Reset mid-operation: everything clears. The first partial line and frame after reset are never measured (have_h/have_v), so relock takes at least LOCK_FRAMES+1 vsync starts.

Decomposition:
- vga_timing_pkg holds H_TOTAL, V_TOTAL, H_START, V_START, H_DISPLAY, V_DISPLAY and SYNC_POL defaults. The generator shares this package.
- One sub-module: sync_edge_detect (polarity normalise, tick-qualified register, start-edge pulse). It is instantiated twice, for hsync and vsync.

Test Plan:
- Golden stream: generator output, pixel_tick every 2nd clk, 3 frames.
  - locked rises at the frame_start ending the 3rd vsync-delimited frame.
  - h_total=800, v_total=525.
  - pixel_x/pixel_y read 0/0 one tick after generator pixel (0,0), and 639/479 at (639,479).
  - video_on is high for exactly 307200 ticks per frame.
- Long line: one line stretched to 801 ticks mid-frame.
  - h_total=801 and locked=0 on that hs_start tick.
  - video_on is low immediately.
  - Relock after 2 clean frames.
- Mid-frame reset: 3-clk reset at line 200.
  - All outputs 0 on the next clk.
  - locked stays 0 until the 3rd frame_start after reset.
- Hsync stuck deasserted for 3000 ticks: h_cnt saturates at 2047 without wrap; locked=0, video_on=0.
- Polarity and stall:
  - SYNC_POL=1 with inverted syncs gives results identical to the golden-stream test.
  - Holding pixel_tick low for 50 clk leaves every output unchanged.
- Coincident vs_start and hs_start on one tick: v_cnt=0 and a single frame_start pulse on that tick.
